// File: rtl/shift_reg_n.sv
// N-bit shift/rotate register: parallel load, then a multi-cycle shift or rotate of a
// programmable count, one bit per enabled clock, with busy/done/carry status.
module shift_reg_n #(
  parameter  int unsigned N  = 8,
  localparam int unsigned CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          load,
  input  logic [N-1:0]  d,
  input  logic          start,
  input  logic [2:0]    mode,
  input  logic [CW-1:0] amt,
  input  logic          serial_in,
  output logic [N-1:0]  q,
  output logic          busy,
  output logic          done,
  output logic          carry
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  localparam logic [2:0] ModeSll  = 3'd0;
  localparam logic [2:0] ModeSrl  = 3'd1;
  localparam logic [2:0] ModeSra  = 3'd2;
  localparam logic [2:0] ModeRol  = 3'd3;
  localparam logic [2:0] ModeRor  = 3'd4;
  localparam logic [2:0] ModeSls  = 3'd5;
  localparam logic [2:0] ModeSrs  = 3'd6;
  localparam logic [2:0] ModeHold = 3'd7;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  q_q, q_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    mode_q, mode_d;

  logic [N-1:0]  step_q;
  logic          step_carry;

  // One shift step on the current contents, using the mode captured at start.
  always_comb begin
    step_q     = q_q;
    step_carry = 1'b0;
    case (mode_q)
      ModeSll: begin
        step_q     = {q_q[N-2:0], 1'b0};
        step_carry = q_q[N-1];
      end
      ModeSrl: begin
        step_q     = {1'b0, q_q[N-1:1]};
        step_carry = q_q[0];
      end
      ModeSra: begin
        step_q     = {q_q[N-1], q_q[N-1:1]};
        step_carry = q_q[0];
      end
      ModeRol: begin
        step_q     = {q_q[N-2:0], q_q[N-1]};
        step_carry = q_q[N-1];
      end
      ModeRor: begin
        step_q     = {q_q[0], q_q[N-1:1]};
        step_carry = q_q[0];
      end
      ModeSls: begin
        step_q     = {q_q[N-2:0], serial_in};
        step_carry = q_q[N-1];
      end
      ModeSrs: begin
        step_q     = {serial_in, q_q[N-1:1]};
        step_carry = q_q[0];
      end
      ModeHold: begin
        step_q     = q_q;
        step_carry = 1'b0;
      end
      default: begin
        step_q     = q_q;
        step_carry = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    carry_d = carry_q;
    count_d = count_q;
    mode_d  = mode_q;
    if (en) begin
      case (state_q)
        StIdle: begin
          // Load has priority over start when both are asserted.
          if (load) begin
            q_d     = d;
            carry_d = 1'b0;
          end else if (start) begin
            mode_d = mode;
            if (amt == '0) begin
              state_d = StDone;
            end else begin
              count_d = amt;
              state_d = StShift;
            end
          end
        end
        StShift: begin
          q_d     = step_q;
          carry_d = step_carry;
          count_d = count_q - CW'(1);
          if (count_q == CW'(1)) begin
            state_d = StDone;
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      q_q     <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      mode_q  <= ModeSll;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      carry_q <= carry_d;
      count_q <= count_d;
      mode_q  <= mode_d;
    end
  end

  assign q     = q_q;
  assign carry = carry_q;
  assign busy  = (state_q == StShift);
  assign done  = (state_q == StDone);

endmodule

// File: tb/tb_shift_reg_n.sv
// Directed bench for shift_reg_n (N=8): load/shift/rotate modes, zero count, stalls,
// ignored load during shift and asynchronous reset mid-operation.
module tb_shift_reg_n;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [7:0] d;
  logic       start;
  logic [2:0] mode;
  logic [2:0] amt;
  logic       serial_in;
  logic [7:0] q;
  logic       busy;
  logic       done;
  logic       carry;

  int n_vec;
  int n_bad;

  shift_reg_n #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load      (load),
    .d         (d),
    .start     (start),
    .mode      (mode),
    .amt       (amt),
    .serial_in (serial_in),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .carry     (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [7:0] val);
    load = 1'b1;
    d    = val;
    tick();
    load = 1'b0;
  endtask

  // Start an operation, count busy cycles (bounded), then check the done pulse.
  task automatic run_op(input string tag, input logic [2:0] m, input logic [2:0] a,
                        input int exp_busy);
    int nb;
    int guard;
    mode  = m;
    amt   = a;
    start = 1'b1;
    tick();
    start = 1'b0;
    mode  = 3'd0;
    amt   = 3'd0;
    nb    = 0;
    guard = 0;
    while (busy && guard < 40) begin
      nb++;
      guard++;
      tick();
    end
    chk({tag, "_busy_cycles"}, nb, exp_busy);
    chk({tag, "_done_hi"}, done, 1'b1);
    tick();
    chk({tag, "_done_lo"}, done, 1'b0);
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    int nb;
    n_vec     = 0;
    n_bad     = 0;
    rst       = 1'b0;
    en        = 1'b1;
    load      = 1'b0;
    d         = 8'h00;
    start     = 1'b0;
    mode      = 3'd0;
    amt       = 3'd0;
    serial_in = 1'b0;
    #12;
    chk("rst_q", q, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_carry", carry, 1'b0);
    rst = 1'b1;
    tick();

    // SLL by 3
    do_load(8'hB5);
    chk("load_b5", q, 8'hB5);
    run_op("sll3", 3'd0, 3'd3, 3);
    chk("sll3_q", q, 8'hA8);
    chk("sll3_c", carry, 1'b1);

    // SRA, ROR, zero count, HOLD, ROL
    do_load(8'h96);
    run_op("sra2", 3'd2, 3'd2, 2);
    chk("sra2_q", q, 8'hE5);
    chk("sra2_c", carry, 1'b1);
    do_load(8'h81);
    run_op("ror1", 3'd4, 3'd1, 1);
    chk("ror1_q", q, 8'hC0);
    chk("ror1_c", carry, 1'b1);
    run_op("amt0", 3'd1, 3'd0, 0);
    chk("amt0_q", q, 8'hC0);
    chk("amt0_c", carry, 1'b1);
    run_op("hold2", 3'd7, 3'd2, 2);
    chk("hold2_q", q, 8'hC0);
    chk("hold2_c", carry, 1'b0);
    do_load(8'h01);
    run_op("rol7", 3'd3, 3'd7, 7);
    chk("rol7_q", q, 8'h80);
    chk("rol7_c", carry, 1'b0);

    // Serial fill modes
    serial_in = 1'b1;
    do_load(8'h00);
    run_op("sls4", 3'd5, 3'd4, 4);
    chk("sls4_q", q, 8'h0F);
    chk("sls4_c", carry, 1'b0);
    do_load(8'h00);
    run_op("srs4", 3'd6, 3'd4, 4);
    chk("srs4_q", q, 8'hF0);
    chk("srs4_c", carry, 1'b0);
    serial_in = 1'b0;

    // Load and start together: load wins
    load  = 1'b1;
    start = 1'b1;
    d     = 8'h3C;
    mode  = 3'd0;
    amt   = 3'd2;
    tick();
    load  = 1'b0;
    start = 1'b0;
    chk("ldst_q", q, 8'h3C);
    chk("ldst_busy", busy, 1'b0);
    chk("ldst_done", done, 1'b0);
    tick();
    chk("ldst_busy2", busy, 1'b0);

    // SLL by 4 with a 2-cycle stall and a load attempt mid-shift
    do_load(8'h33);
    mode  = 3'd0;
    amt   = 3'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    nb    = busy ? 1 : 0;
    tick();
    nb += busy ? 1 : 0;
    en = 1'b0;
    tick();
    nb += busy ? 1 : 0;
    chk("stall_q", q, 8'h66);
    tick();
    nb += busy ? 1 : 0;
    en   = 1'b1;
    load = 1'b1;
    d    = 8'hFF;
    tick();
    load = 1'b0;
    nb += busy ? 1 : 0;
    tick();
    nb += busy ? 1 : 0;
    tick();
    nb += busy ? 1 : 0;
    chk("stall_busy_cycles", nb, 6);
    chk("stall_q_final", q, 8'h30);
    chk("stall_c_final", carry, 1'b1);
    chk("stall_done", done, 1'b1);
    en = 1'b0;
    tick();
    chk("done_stretch", done, 1'b1);
    en = 1'b1;
    tick();
    chk("done_clear", done, 1'b0);

    // Asynchronous reset between edges mid-shift
    do_load(8'hFF);
    mode  = 3'd1;
    amt   = 3'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("pre_rst_q", q, 8'h7F);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_q", q, 8'h00);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_carry", carry, 1'b0);
    #1;
    rst = 1'b1;
    tick();
    do_load(8'h0F);
    run_op("post_rst", 3'd0, 3'd1, 1);
    chk("post_rst_q", q, 8'h1E);
    chk("post_rst_c", carry, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
